// File: rtl/seq_multiplier_param_pkg.sv
// Shared definitions for the parametrised shift-add multiplier: FSM encoding and
// counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier_param_if.sv
// Request/response bundle of the sequential multiplier.
interface seq_multiplier_param_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, product
    );

endinterface

// File: rtl/seq_multiplier_param_abs.sv
// Conditional two's-complement negate; used both for operand magnitudes and to
// restore the sign of the result.
module mult_abs_unit #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, one partial product per clock, with optional
// two's-complement operand mode and a busy/done handshake.
module seq_multiplier_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    seq_multiplier_param_if.slave bus
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mag_a_q, mag_a_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     product_q, product_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [PW-1:0]     signed_acc;

    mult_abs_unit #(.W(WIDTH)) u_abs_a (
        .value  (bus.a),
        .negate (bus.signed_mode & bus.a[WIDTH-1]),
        .result (abs_a)
    );

    mult_abs_unit #(.W(WIDTH)) u_abs_b (
        .value  (bus.b),
        .negate (bus.signed_mode & bus.b[WIDTH-1]),
        .result (abs_b)
    );

    mult_abs_unit #(.W(PW)) u_abs_p (
        .value  (acc_q),
        .negate (neg_q),
        .result (signed_acc)
    );

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + ({{WIDTH{1'b0}}, mag_a_q} << cnt_q);
                end
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                // Always run the full count so latency does not depend on data.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                product_d = signed_acc;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param: 16-bit and 8-bit instances, a timestamp-based
// reference model checked every cycle, plus directed literal expectations.
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_param_if #(.WIDTH(16)) bus16 ();
    seq_multiplier_param_if #(.WIDTH(8))  bus8 ();

    seq_multiplier_param #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
    seq_multiplier_param #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Plain integer multiply of the operands as the mode says, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(int unsigned w, logic [31:0] a, logic [31:0] b,
                                            bit s);
        longint sa, sb;
        logic [63:0] p, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p    = 64'(sa * sb);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return p & mask;
    endfunction

    // Model: an accepted request completes W+1 edges later; requests in flight block others.
    logic        m16_pend, m16_done;
    int          m16_due;
    logic [63:0] m16_exp, m16_prod;
    logic        m8_pend, m8_done;
    int          m8_due;
    logic [63:0] m8_exp, m8_prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m16_pend <= 1'b0; m16_done <= 1'b0; m16_prod <= '0; m16_due <= 0; m16_exp <= '0;
        end else begin
            m16_done <= 1'b0;
            if (m16_pend && (cyc + 1 == m16_due)) begin
                m16_pend <= 1'b0;
                m16_done <= 1'b1;
                m16_prod <= m16_exp;
            end
            if (!m16_pend && bus16.start) begin
                m16_pend <= 1'b1;
                m16_due  <= cyc + 1 + 17;
                m16_exp  <= ref_mul(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.signed_mode);
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m8_pend <= 1'b0; m8_done <= 1'b0; m8_prod <= '0; m8_due <= 0; m8_exp <= '0;
        end else begin
            m8_done <= 1'b0;
            if (m8_pend && (cyc + 1 == m8_due)) begin
                m8_pend <= 1'b0;
                m8_done <= 1'b1;
                m8_prod <= m8_exp;
            end
            if (!m8_pend && bus8.start) begin
                m8_pend <= 1'b1;
                m8_due  <= cyc + 1 + 9;
                m8_exp  <= ref_mul(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk(bus16.busy == m16_pend, "m16_busy", longint'(bus16.busy), longint'(m16_pend));
            chk(bus16.done == m16_done, "m16_done", longint'(bus16.done), longint'(m16_done));
            chk(bus16.product == m16_prod[31:0], "m16_product",
                longint'(bus16.product), longint'(m16_prod[31:0]));
            chk(bus8.busy == m8_pend, "m8_busy", longint'(bus8.busy), longint'(m8_pend));
            chk(bus8.done == m8_done, "m8_done", longint'(bus8.done), longint'(m8_done));
            chk(bus8.product == m8_prod[15:0], "m8_product",
                longint'(bus8.product), longint'(m8_prod[15:0]));
        end
    end

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                           output int e);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.signed_mode = sm;
        @(posedge clk); #1;
        e = cyc;
        bus16.start = 1'b0; bus16.a = $urandom; bus16.b = $urandom;
        bus16.signed_mode = $urandom_range(0, 1);
    endtask

    task automatic wait16(input int e, input logic [31:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus16.done) seen = 1'b1;
        end
        chk(seen, {name, "_timeout"}, longint'(seen), 1);
        if (seen) begin
            chk(bus16.product == exp, {name, "_product"}, longint'(bus16.product), longint'(exp));
            chk(cyc - e == 17, {name, "_latency"}, longint'(cyc - e), 17);
            chk(bus16.busy == 1'b0, {name, "_busy"}, longint'(bus16.busy), 0);
        end
    endtask

    task automatic wait8(input int e, input logic [15:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
        end
        chk(seen, {name, "_timeout"}, longint'(seen), 1);
        if (seen) begin
            chk(bus8.product == exp, {name, "_product"}, longint'(bus8.product), longint'(exp));
            chk(cyc - e == 9, {name, "_latency"}, longint'(cyc - e), 9);
        end
    endtask

    initial begin
        int e;
        int dones;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0;
        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.signed_mode  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk(bus16.busy == 1'b0, "rst_busy", longint'(bus16.busy), 0);
        chk(bus16.done == 1'b0, "rst_done", longint'(bus16.done), 0);
        chk(bus16.product == 32'd0, "rst_product", longint'(bus16.product), 0);
        reset = 1'b0;

        start16(16'd10, 16'd20, 1'b0, e);
        wait16(e, 32'd200, "u10x20");
        start16(16'hFFFF, 16'hFFFF, 1'b0, e);
        wait16(e, 32'hFFFE0001, "uffff");
        start16(16'hFFFF, 16'hFFFF, 1'b1, e);
        wait16(e, 32'h00000001, "sm1xm1");
        start16(16'hFFFD, 16'd5, 1'b1, e);
        wait16(e, 32'hFFFFFFF1, "sm3x5");
        start16(16'h8000, 16'h8000, 1'b1, e);
        wait16(e, 32'h40000000, "sminxmin");
        start16(16'd0, 16'hFFF9, 1'b1, e);
        wait16(e, 32'd0, "s0xm7");

        // A second start mid-operation must be ignored.
        start16(16'd100, 16'd25, 1'b0, e);
        repeat (4) @(posedge clk);
        #1;
        bus16.start = 1'b1; bus16.a = 16'd1234; bus16.b = 16'd5678;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        wait16(e, 32'd2500, "ignored_start");
        start16(16'd1234, 16'd5678, 1'b0, e);
        wait16(e, 32'd7006652, "u1234x5678");

        // Asynchronous abort mid-operation.
        start16(16'd100, 16'd3, 1'b0, e);
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk(bus16.busy == 1'b0, "abort_busy", longint'(bus16.busy), 0);
        chk(bus16.done == 1'b0, "abort_done", longint'(bus16.done), 0);
        chk(bus16.product == 32'd0, "abort_product", longint'(bus16.product), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus16.done) dones++;
        end
        chk(dones == 0, "abort_no_done", longint'(dones), 0);
        start16(16'd7, 16'd9, 1'b0, e);
        wait16(e, 32'd63, "u7x9");

        // 8-bit instance, then a start raised in the done cycle.
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h7F; bus8.signed_mode = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        bus8.start = 1'b0;
        wait8(e, 16'hC080, "w8_min_x_127");
        bus8.start = 1'b1; bus8.a = 8'd5; bus8.b = 8'hFD; bus8.signed_mode = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        bus8.start = 1'b0;
        wait8(e, 16'hFFF1, "w8_back_to_back");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
